pixel_word_packer: RTL and testbench



---
 rtl/pixel_pack_pkg.sv | 25 ++
 rtl/pack_shift_reg.sv | 43 ++++
 rtl/pixel_word_packer.sv | 142 ++++++++++++++
 tb/tb_pixel_word_packer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pack_pkg.sv
// Shared types and elaboration helpers for the pixel-to-word packer.
package pixel_pack_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StFlush,
        StDrain
    } pack_state_e;

    function automatic int unsigned pix_per_word(input int unsigned pix_w,
                                                 input int unsigned word_w);
        return word_w / pix_w;
    endfunction

    // Counter width for n states; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit widths_ok(input int unsigned pix_w, input int unsigned word_w);
        return (pix_w != 0) && (word_w >= pix_w) && ((word_w % pix_w) == 0);
    endfunction

endpackage

// File: rtl/pack_shift_reg.sv
// Slot-indexed pack register: writes one pixel into its slot, exposes the word with
// the incoming pixel already merged so a completing pixel can be emitted without delay.
module pack_shift_reg
    import pixel_pack_pkg::*;
#(
    parameter int unsigned PIX_W  = 1,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned SLOT_W = cnt_width(pix_per_word(PIX_W, WORD_W))
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCLEAR,
    input  logic              iWE,
    input  logic [SLOT_W-1:0] iSLOT,
    input  logic [PIX_W-1:0]  iDATA,
    output logic [WORD_W-1:0] oWORD,
    output logic [WORD_W-1:0] oMERGED
);

    localparam int unsigned PPW = pix_per_word(PIX_W, WORD_W);

    logic [WORD_W-1:0] word_q;

    always_comb begin
        oMERGED = word_q;
        for (int k = 0; k < PPW; k++) begin
            if (iSLOT == SLOT_W'(k)) begin
                oMERGED[k*PIX_W +: PIX_W] = iDATA;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST || iCLEAR) begin
            word_q <= '0;
        end else if (iWE) begin
            word_q <= oMERGED;
        end
    end

    assign oWORD = word_q;

endmodule

// File: rtl/pixel_word_packer.sv
// Frame-aware packer: thresholded pixels into WORD_W-bit words with line/frame flush,
// single-entry valid/ready output register and sticky overflow on dropped words.
module pixel_word_packer
    import pixel_pack_pkg::*;
#(
    parameter int unsigned PIX_W      = 1,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LINE_PIX   = 640,
    parameter int unsigned LINE_FLUSH = 1
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iFVAL,
    input  logic              iDVAL,
    input  logic [PIX_W-1:0]  iDATA,
    input  logic              iREADY,
    output logic [WORD_W-1:0] oDATA,
    output logic              oDVAL,
    output logic              oFRAME_DONE,
    output logic              oOVERFLOW,
    output logic [31:0]       oWORD_CNT
);

    localparam int unsigned PPW    = pix_per_word(PIX_W, WORD_W);
    localparam int unsigned SLOT_W = cnt_width(PPW);
    localparam int unsigned LINE_W = cnt_width(LINE_PIX);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PPW - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINE_PIX - 1);

    if (!widths_ok(PIX_W, WORD_W)) begin : g_width_check
        $error("pixel_word_packer: WORD_W must be a non-zero multiple of PIX_W");
    end

    pack_state_e       state_q;
    logic              fval_q;
    logic [SLOT_W-1:0] slot_q;
    logic [LINE_W-1:0] line_q;

    logic [WORD_W-1:0] pack_word;
    logic [WORD_W-1:0] pack_merged;
    logic [WORD_W-1:0] done_data;
    logic              frame_start;
    logic              pix_fire;
    logic              line_end;
    logic              word_full;
    logic              flush_word;
    logic              word_done;
    logic              word_load;
    logic              word_accept;
    logic              pack_clear;

    always_comb begin
        frame_start = (state_q == StIdle) && iFVAL && !fval_q;
        pix_fire    = (state_q == StActive) && iDVAL;
        line_end    = (LINE_FLUSH != 0) && (line_q == LINE_LAST);
        word_full   = pix_fire && ((slot_q == SLOT_LAST) || line_end);
        flush_word  = (state_q == StFlush) && (slot_q != '0);
        word_done   = word_full || flush_word;
        // A completing pixel is not yet in the register, so emit the merged view.
        done_data   = word_full ? pack_merged : pack_word;
        word_accept = oDVAL && iREADY;
        word_load   = word_done && (!oDVAL || iREADY);
        pack_clear  = word_done || (state_q == StFlush) || frame_start;
    end

    pack_shift_reg #(
        .PIX_W  (PIX_W),
        .WORD_W (WORD_W),
        .SLOT_W (SLOT_W)
    ) u_pack (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iCLEAR  (pack_clear),
        .iWE     (pix_fire),
        .iSLOT   (slot_q),
        .iDATA   (iDATA),
        .oWORD   (pack_word),
        .oMERGED (pack_merged)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= StIdle;
            fval_q      <= 1'b0;
            slot_q      <= '0;
            line_q      <= '0;
            oDATA       <= '0;
            oDVAL       <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oOVERFLOW   <= 1'b0;
            oWORD_CNT   <= '0;
        end else begin
            fval_q      <= iFVAL;
            oFRAME_DONE <= 1'b0;

            if (word_accept) begin
                oWORD_CNT <= oWORD_CNT + 32'd1;
                oDVAL     <= 1'b0;
            end
            if (word_load) begin
                oDATA <= done_data;
                oDVAL <= 1'b1;
            end else if (word_done) begin
                oOVERFLOW <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (frame_start) begin
                        state_q   <= StActive;
                        oOVERFLOW <= 1'b0;
                        oWORD_CNT <= '0;
                        slot_q    <= '0;
                        line_q    <= '0;
                    end
                end
                StActive: begin
                    if (pix_fire) begin
                        slot_q <= word_full ? '0 : slot_q + SLOT_W'(1);
                        line_q <= (line_q == LINE_LAST) ? '0 : line_q + LINE_W'(1);
                    end
                    if (!iFVAL && fval_q) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    slot_q  <= '0;
                    line_q  <= '0;
                    state_q <= StDrain;
                end
                StDrain: begin
                    if (!oDVAL) begin
                        oFRAME_DONE <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed bench: three packer configurations sharing strobe/ready/reset, each frame
// driven on one instance while the others sit idle.
module tb_pixel_word_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       dval;
    logic       ready;
    logic       fval_a, fval_b, fval_c;
    logic       d1;
    logic [7:0] d8;

    logic [31:0] a_data, b_data, c_data;
    logic        a_dval, b_dval, c_dval;
    logic        a_fd, b_fd, c_fd;
    logic        a_ovf, b_ovf, c_ovf;
    logic [31:0] a_cnt, b_cnt, c_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] q_c[$];

    // A: 1-bit pixels, 20-pixel lines flushed at line end
    pixel_word_packer #(.PIX_W(1), .WORD_W(32), .LINE_PIX(20), .LINE_FLUSH(1)) u_dut_a (
        .iCLK(clk), .iRST(rst), .iFVAL(fval_a), .iDVAL(dval), .iDATA(d1), .iREADY(ready),
        .oDATA(a_data), .oDVAL(a_dval), .oFRAME_DONE(a_fd), .oOVERFLOW(a_ovf),
        .oWORD_CNT(a_cnt)
    );

    // B: 1-bit pixels, packing across lines
    pixel_word_packer #(.PIX_W(1), .WORD_W(32), .LINE_PIX(640), .LINE_FLUSH(0)) u_dut_b (
        .iCLK(clk), .iRST(rst), .iFVAL(fval_b), .iDVAL(dval), .iDATA(d1), .iREADY(ready),
        .oDATA(b_data), .oDVAL(b_dval), .oFRAME_DONE(b_fd), .oOVERFLOW(b_ovf),
        .oWORD_CNT(b_cnt)
    );

    // C: 8-bit pixels
    pixel_word_packer #(.PIX_W(8), .WORD_W(32), .LINE_PIX(640), .LINE_FLUSH(1)) u_dut_c (
        .iCLK(clk), .iRST(rst), .iFVAL(fval_c), .iDVAL(dval), .iDATA(d8), .iREADY(ready),
        .oDATA(c_data), .oDVAL(c_dval), .oFRAME_DONE(c_fd), .oOVERFLOW(c_ovf),
        .oWORD_CNT(c_cnt)
    );

    always @(negedge clk) begin
        if (a_dval && ready) q_a.push_back(a_data);
        if (b_dval && ready) q_b.push_back(b_data);
        if (c_dval && ready) q_c.push_back(c_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input logic [7:0] v);
        dval = 1'b1;
        d1   = v[0];
        d8   = v;
        tick();
        dval = 1'b0;
    endtask

    task automatic begin_frame(input int sel);
        case (sel)
            0: fval_a = 1'b1;
            1: fval_b = 1'b1;
            default: fval_c = 1'b1;
        endcase
        repeat (3) tick();
    endtask

    task automatic end_frame(input int sel, output int pulses);
        dval   = 1'b0;
        pulses = 0;
        case (sel)
            0: fval_a = 1'b0;
            1: fval_b = 1'b0;
            default: fval_c = 1'b0;
        endcase
        repeat (40) begin
            tick();
            case (sel)
                0: if (a_fd) pulses++;
                1: if (b_fd) pulses++;
                default: if (c_fd) pulses++;
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        rst = 1'b1; dval = 1'b0; ready = 1'b1; d1 = 1'b0; d8 = 8'h00;
        fval_a = 1'b0; fval_b = 1'b0; fval_c = 1'b0;
        repeat (3) tick();
        check("rst_b_data", b_data, 32'h0);
        check("rst_b_dval", 32'(b_dval), 32'd0);
        check("rst_b_fd", 32'(b_fd), 32'd0);
        check("rst_b_ovf", 32'(b_ovf), 32'd0);
        check("rst_b_cnt", b_cnt, 32'd0);
        check("rst_c_data", c_data, 32'h0);
        rst = 1'b0;
        tick();

        // 640 alternating pixels, no line flush
        q_b.delete();
        begin_frame(1);
        for (int k = 0; k < 640; k++) pixel(8'((k % 2 == 0) ? 1 : 0));
        end_frame(1, p);
        check("t1_pulses", 32'(p), 32'd1);
        check("t1_nwords", 32'(q_b.size()), 32'd20);
        for (int i = 0; i < q_b.size(); i++) check($sformatf("t1_word%0d", i), q_b[i], 32'h55555555);
        check("t1_cnt", b_cnt, 32'd20);
        check("t1_ovf", 32'(b_ovf), 32'd0);

        // 3 lines of 20 ones, each flushed as a padded word
        q_a.delete();
        begin_frame(0);
        repeat (60) pixel(8'd1);
        end_frame(0, p);
        check("t2_pulses", 32'(p), 32'd1);
        check("t2_nwords", 32'(q_a.size()), 32'd3);
        for (int i = 0; i < q_a.size(); i++) check($sformatf("t2_word%0d", i), q_a[i], 32'h000FFFFF);
        check("t2_cnt", a_cnt, 32'd3);
        check("t2_ovf", 32'(a_ovf), 32'd0);

        // 8-bit pixels, frame-end flush of a partial word
        q_c.delete();
        begin_frame(2);
        pixel(8'h11); pixel(8'h22); pixel(8'h33); pixel(8'h44); pixel(8'h55);
        end_frame(2, p);
        check("t3_pulses", 32'(p), 32'd1);
        check("t3_nwords", 32'(q_c.size()), 32'd2);
        if (q_c.size() >= 2) begin
            check("t3_word0", q_c[0], 32'h44332211);
            check("t3_word1", q_c[1], 32'h00000055);
        end
        check("t3_cnt", c_cnt, 32'd2);

        // backpressure: first word held, later completions dropped
        q_b.delete();
        ready = 1'b0;
        begin_frame(1);
        for (int k = 0; k < 96; k++) begin
            pixel(8'((k < 16) ? 1 : (k < 32) ? 0 : (k < 64) ? 1 : (k % 2)));
            if (k == 31) begin
                check("t4_dval_first", 32'(b_dval), 32'd1);
                check("t4_data_first", b_data, 32'h0000FFFF);
            end
            if (k == 62) check("t4_ovf_before", 32'(b_ovf), 32'd0);
            if (k == 63) begin
                check("t4_ovf_after", 32'(b_ovf), 32'd1);
                check("t4_data_held", b_data, 32'h0000FFFF);
            end
        end
        check("t4_data_end", b_data, 32'h0000FFFF);
        check("t4_cnt_held", b_cnt, 32'd0);
        ready = 1'b1;
        tick();
        check("t4_cnt_accept", b_cnt, 32'd1);
        check("t4_dval_accept", 32'(b_dval), 32'd0);
        end_frame(1, p);
        check("t4_pulses", 32'(p), 32'd1);
        check("t4_nwords", 32'(q_b.size()), 32'd1);
        if (q_b.size() >= 1) check("t4_word0", q_b[0], 32'h0000FFFF);
        check("t4_ovf_sticky", 32'(b_ovf), 32'd1);

        // reset mid-frame with a word held and 17 pixels pending
        q_b.delete();
        ready = 1'b0;
        begin_frame(1);
        check("t5_ovf_cleared", 32'(b_ovf), 32'd0);
        check("t5_cnt_cleared", b_cnt, 32'd0);
        repeat (49) pixel(8'd1);
        check("t5_dval_pre", 32'(b_dval), 32'd1);
        check("t5_data_pre", b_data, 32'hFFFFFFFF);
        rst = 1'b1;
        fval_b = 1'b0;
        tick();
        check("t5_rst_data", b_data, 32'h0);
        check("t5_rst_dval", 32'(b_dval), 32'd0);
        check("t5_rst_fd", 32'(b_fd), 32'd0);
        check("t5_rst_cnt", b_cnt, 32'd0);
        rst = 1'b0;
        p = 0;
        repeat (3) begin
            tick();
            if (b_fd) p++;
        end
        check("t5_no_fd", 32'(p), 32'd0);
        ready = 1'b1;
        begin_frame(1);
        for (int k = 0; k < 32; k++) pixel(8'(k < 8));
        end_frame(1, p);
        check("t5_pulses", 32'(p), 32'd1);
        check("t5_nwords", 32'(q_b.size()), 32'd1);
        if (q_b.size() >= 1) check("t5_word0", q_b[0], 32'h000000FF);
        check("t5_cnt", b_cnt, 32'd1);

        // completion coinciding with acceptance of the held word
        q_c.delete();
        ready = 1'b0;
        begin_frame(2);
        pixel(8'h01); pixel(8'h02); pixel(8'h03); pixel(8'h04);
        check("t6_dval_held", 32'(c_dval), 32'd1);
        check("t6_data_held", c_data, 32'h04030201);
        pixel(8'h05); pixel(8'h06); pixel(8'h07);
        ready = 1'b1;
        pixel(8'h08);
        check("t6_dval_swap", 32'(c_dval), 32'd1);
        check("t6_data_swap", c_data, 32'h08070605);
        check("t6_ovf", 32'(c_ovf), 32'd0);
        check("t6_cnt_swap", c_cnt, 32'd1);
        tick();
        check("t6_cnt_final", c_cnt, 32'd2);
        check("t6_dval_final", 32'(c_dval), 32'd0);
        end_frame(2, p);
        check("t6_pulses", 32'(p), 32'd1);
        check("t6_nwords", 32'(q_c.size()), 32'd2);
        if (q_c.size() >= 2) begin
            check("t6_word0", q_c[0], 32'h04030201);
            check("t6_word1", q_c[1], 32'h08070605);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
